pipeline_hazard_ctrl: RTL and testbench

Central hazard controller for the 5-stage RV32I pipeline (IF/ID/EX/MEM/WB).
- Keeps shadow copies of each in-flight instruction's destination/source register and write controls, advancing through EX, MEM and WB.
- Generates per-stage stall/flush and EX-stage forwarding selects.
- Runs a short post-reset flush sequence so that no garbage instruction commits.
- Sits beside the stage modules; its outputs gate the IF/ID and ID/EX pipeline registers and the EX operand muxes.

---
 rtl/riscv_pkg.sv | 31 +++
 rtl/hazard_fwd_sel.sv | 34 +++
 rtl/pipeline_hazard_ctrl.sv | 160 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32I pipeline hazard controller: forwarding
// encodings, load marker, controller FSM states and shadow stage entries.
package riscv_pkg;

  localparam int REG_AW = 5;

  localparam logic [1:0] FWD_REG     = 2'b00;
  localparam logic [1:0] FWD_WB      = 2'b01;
  localparam logic [1:0] FWD_MEM     = 2'b10;
  localparam logic [1:0] RESULT_LOAD = 2'b01;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } hz_state_e;

  typedef struct packed {
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic              regwrite;
    logic [1:0]        result_src;
  } stage_ent_t;

  // MEM/WB only need to know which register is written.
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic              regwrite;
  } wr_ent_t;

endpackage

// File: rtl/hazard_fwd_sel.sv
// EX operand forwarding select for one source register; MEM beats WB and
// writes to x0 never forward.
module hazard_fwd_sel
  import riscv_pkg::*;
#(
  parameter int AW = REG_AW
) (
  input  logic [AW-1:0] i_rs_e,
  input  logic [AW-1:0] i_rd_m,
  input  logic          i_regwrite_m,
  input  logic [AW-1:0] i_rd_w,
  input  logic          i_regwrite_w,
  output logic [1:0]    o_sel
);

  logic w_hit_m;
  logic w_hit_w;

  assign w_hit_m = i_regwrite_m && (i_rd_m != {AW{1'b0}}) && (i_rd_m == i_rs_e);
  assign w_hit_w = i_regwrite_w && (i_rd_w != {AW{1'b0}}) && (i_rd_w == i_rs_e);

  // Priority select between MEM, WB and the register file.
  always_comb begin
    o_sel = FWD_REG;
    if (w_hit_m) begin
      o_sel = FWD_MEM;
    end else if (w_hit_w) begin
      o_sel = FWD_WB;
    end else begin
      o_sel = FWD_REG;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush/forwarding controller for the 5-stage RV32I pipeline.
// Optional event counters are enabled with the HAZARD_PERF_EN macro.
module pipeline_hazard_ctrl
  import riscv_pkg::*;
#(
  parameter int REG_AW     = riscv_pkg::REG_AW,
  parameter int INIT_FLUSH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] rs1_d,
  input  logic [REG_AW-1:0] rs2_d,
  input  logic [REG_AW-1:0] rd_d,
  input  logic              regwrite_d,
  input  logic [1:0]        result_src_d,
  input  logic              pc_src_e,
  output logic              stall_f,
  output logic              stall_d,
  output logic              flush_d,
  output logic              flush_e,
  output logic [1:0]        forward_a_e,
  output logic [1:0]        forward_b_e,
  output logic              busy
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  localparam logic [3:0] INIT_LOAD = 4'(INIT_FLUSH - 1);

  hz_state_e  r_state;
  hz_state_e  w_state_nxt;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;
  stage_ent_t r_e;
  wr_ent_t    r_m;
  wr_ent_t    r_w;
  logic       w_lwstall;

  // Controller state and post-reset flush countdown.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= INIT;
      r_cnt   <= INIT_LOAD;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state: leave INIT on the edge where the countdown reaches zero.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      INIT: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = RUN;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      RUN: begin
        w_state_nxt = RUN;
      end
      default: begin
        w_state_nxt = INIT;
        w_cnt_nxt   = INIT_LOAD;
      end
    endcase
  end

  assign w_lwstall = (r_state == RUN) && (r_e.result_src == RESULT_LOAD) && r_e.regwrite &&
                     (r_e.rd != {REG_AW{1'b0}}) && ((r_e.rd == rs1_d) || (r_e.rd == rs2_d));

  // Stall/flush outputs; a taken branch overrides a load-use stall.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    flush_d = 1'b1;
    flush_e = 1'b1;
    busy    = 1'b1;
    case (r_state)
      INIT: begin
        busy = 1'b1;
      end
      RUN: begin
        busy    = 1'b0;
        stall_f = w_lwstall && !pc_src_e;
        stall_d = w_lwstall && !pc_src_e;
        flush_d = pc_src_e;
        flush_e = w_lwstall || pc_src_e;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

  // Shadow copies of the instructions in EX, MEM and WB.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_e <= {$bits(stage_ent_t){1'b0}};
      r_m <= {$bits(wr_ent_t){1'b0}};
      r_w <= {$bits(wr_ent_t){1'b0}};
    end else begin
      if (flush_e) begin
        r_e <= {$bits(stage_ent_t){1'b0}};
      end else begin
        r_e <= '{rs1: rs1_d, rs2: rs2_d, rd: rd_d, regwrite: regwrite_d, result_src: result_src_d};
      end
      r_m <= '{rd: r_e.rd, regwrite: r_e.regwrite};
      r_w <= r_m;
    end
  end

  hazard_fwd_sel #(.AW(REG_AW)) u_fwd_a (
    .i_rs_e       (r_e.rs1),
    .i_rd_m       (r_m.rd),
    .i_regwrite_m (r_m.regwrite),
    .i_rd_w       (r_w.rd),
    .i_regwrite_w (r_w.regwrite),
    .o_sel        (forward_a_e)
  );

  hazard_fwd_sel #(.AW(REG_AW)) u_fwd_b (
    .i_rs_e       (r_e.rs2),
    .i_rd_m       (r_m.rd),
    .i_regwrite_m (r_m.regwrite),
    .i_rd_w       (r_w.rd),
    .i_regwrite_w (r_w.regwrite),
    .o_sel        (forward_b_e)
  );

`ifdef HAZARD_PERF_EN
  // Event counters, frozen while the post-reset flush is running.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      if ((r_state == RUN) && stall_d) begin
        stall_cnt <= stall_cnt + 32'd1;
      end else begin
        stall_cnt <= stall_cnt;
      end
      if ((r_state == RUN) && pc_src_e) begin
        flush_cnt <= flush_cnt + 32'd1;
      end else begin
        flush_cnt <= flush_cnt;
      end
    end
  end
`else
  // Default build carries no event counters.
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed ID/branch vectors push
// expected outputs, a negedge monitor pops and compares them.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] rs1_d = 5'd0;
  logic [4:0] rs2_d = 5'd0;
  logic [4:0] rd_d = 5'd0;
  logic       regwrite_d = 1'b0;
  logic [1:0] result_src_d = 2'b00;
  logic       pc_src_e = 1'b0;
  logic       stall_f, stall_d, flush_d, flush_e, busy;
  logic [1:0] forward_a_e, forward_b_e;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int tests = 0;
  int failed = 0;
  int cyc = 0;

  typedef struct {
    int         id;
    logic [8:0] v;
  } exp_t;
  exp_t sb_q[$];

  // {stall_f, stall_d, flush_d, flush_e, fwd_a[1:0], fwd_b[1:0], busy}
  localparam logic [8:0] X_Z    = 9'b0_0_0_0_00_00_0;
  localparam logic [8:0] X_INIT = 9'b0_0_1_1_00_00_1;
  localparam logic [8:0] X_LW   = 9'b1_1_0_1_00_00_0;
  localparam logic [8:0] X_BR   = 9'b0_0_1_1_00_00_0;

  function automatic logic [8:0] fw(input logic [1:0] a, input logic [1:0] b);
    return {4'b0000, a, b, 1'b0};
  endfunction

  pipeline_hazard_ctrl #(.REG_AW(5), .INIT_FLUSH(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .rs1_d        (rs1_d),
    .rs2_d        (rs2_d),
    .rd_d         (rd_d),
    .regwrite_d   (regwrite_d),
    .result_src_d (result_src_d),
    .pc_src_e     (pc_src_e),
    .stall_f      (stall_f),
    .stall_d      (stall_d),
    .flush_d      (flush_d),
    .flush_e      (flush_e),
    .forward_a_e  (forward_a_e),
    .forward_b_e  (forward_b_e),
    .busy         (busy)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic step(input logic rst, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [4:0] rd, input logic rw, input logic [1:0] rsrc,
                      input logic pc, input logic [8:0] ex);
    exp_t e;
    @(posedge clk);
    #1;
    reset        = rst;
    rs1_d        = rs1;
    rs2_d        = rs2;
    rd_d         = rd;
    regwrite_d   = rw;
    result_src_d = rsrc;
    pc_src_e     = pc;
    e.id = cyc;
    e.v  = ex;
    sb_q.push_back(e);
    cyc++;
  endtask

  // Monitor: compare the combinational outputs mid-cycle against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    logic [8:0] got;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      got = {stall_f, stall_d, flush_d, flush_e, forward_a_e, forward_b_e, busy};
      tests++;
      if (got !== e.v) begin
        failed++;
        $display("FAIL outs vec%0d got=%b expected=%b (sf sd fd fe fa fb busy)", e.id, got, e.v);
      end
    end
  end

  initial begin
    step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0, X_INIT);
    // INIT: two flush cycles, taken branches ignored.
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b1, X_INIT);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b1, X_INIT);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0, X_Z);
    // add x5; sub x6,x5; or x8,x9,x5; xor -> MEM then WB forwarding.
    step(1'b0, 5'd1, 5'd2, 5'd5, 1'b1, 2'b00, 1'b0, X_Z);
    step(1'b0, 5'd5, 5'd3, 5'd6, 1'b1, 2'b00, 1'b0, X_Z);
    step(1'b0, 5'd9, 5'd5, 5'd8, 1'b1, 2'b00, 1'b0, fw(2'b10, 2'b00));
    step(1'b0, 5'd12, 5'd13, 5'd11, 1'b1, 2'b00, 1'b0, fw(2'b00, 2'b01));
    // lw x7 then consumer of x7: one stall, then WB forward.
    step(1'b0, 5'd1, 5'd0, 5'd7, 1'b1, 2'b01, 1'b0, X_Z);
    step(1'b0, 5'd7, 5'd2, 5'd14, 1'b1, 2'b00, 1'b0, X_LW);
    step(1'b0, 5'd7, 5'd2, 5'd14, 1'b1, 2'b00, 1'b0, X_Z);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0, fw(2'b01, 2'b00));
    // Load to x0 and consumers of x0: no stall, no forward.
    step(1'b0, 5'd1, 5'd0, 5'd0, 1'b1, 2'b01, 1'b0, X_Z);
    step(1'b0, 5'd0, 5'd3, 5'd9, 1'b1, 2'b00, 1'b0, X_Z);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0, X_Z);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0, X_Z);
    // Two writes to x20 in MEM and WB: MEM wins on both operands.
    step(1'b0, 5'd1, 5'd0, 5'd20, 1'b1, 2'b00, 1'b0, X_Z);
    step(1'b0, 5'd2, 5'd0, 5'd20, 1'b1, 2'b00, 1'b0, X_Z);
    step(1'b0, 5'd20, 5'd20, 5'd21, 1'b1, 2'b00, 1'b0, X_Z);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0, fw(2'b10, 2'b10));
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0, X_Z);
    // Load-use coinciding with a taken branch: flush wins.
    step(1'b0, 5'd1, 5'd0, 5'd7, 1'b1, 2'b01, 1'b0, X_Z);
    step(1'b0, 5'd3, 5'd7, 5'd15, 1'b1, 2'b00, 1'b1, X_BR);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0, X_Z);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0, X_Z);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b1, X_BR);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0, X_Z);
    // Two more load-use stalls (via rs2, then rs1).
    step(1'b0, 5'd1, 5'd0, 5'd7, 1'b1, 2'b01, 1'b0, X_Z);
    step(1'b0, 5'd0, 5'd7, 5'd16, 1'b1, 2'b00, 1'b0, X_LW);
    step(1'b0, 5'd0, 5'd7, 5'd16, 1'b1, 2'b00, 1'b0, X_Z);
    step(1'b0, 5'd1, 5'd0, 5'd8, 1'b1, 2'b01, 1'b0, fw(2'b00, 2'b01));
    step(1'b0, 5'd8, 5'd0, 5'd17, 1'b1, 2'b00, 1'b0, X_LW);
    step(1'b0, 5'd8, 5'd0, 5'd17, 1'b1, 2'b00, 1'b0, X_Z);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0, fw(2'b01, 2'b00));
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0, X_Z);
`ifdef HAZARD_PERF_EN
    tests++;
    if (stall_cnt !== 32'd3) begin
      failed++;
      $display("FAIL stall_cnt got=%0d expected=3", stall_cnt);
    end
    tests++;
    if (flush_cnt !== 32'd2) begin
      failed++;
      $display("FAIL flush_cnt got=%0d expected=2", flush_cnt);
    end
`endif
    // Reset mid-RUN returns to INIT at once, then a fresh flush sequence.
    step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0, X_INIT);
`ifdef HAZARD_PERF_EN
    #1;
    tests++;
    if ((stall_cnt !== 32'd0) || (flush_cnt !== 32'd0)) begin
      failed++;
      $display("FAIL perf_reset got=%0d/%0d expected=0/0", stall_cnt, flush_cnt);
    end
`endif
    step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0, X_INIT);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0, X_INIT);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0, X_INIT);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0, X_Z);
    for (int i = 0; i < 10; i++) begin
      if (sb_q.size() > 0) begin
        @(negedge clk);
        #1;
      end
    end
    if (sb_q.size() > 0) begin
      tests++;
      failed++;
      $display("FAIL drain got=%0d pending expected=0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
